// File: rtl/data_memory.sv
// data_memory: main-memory model behind the data cache.
// It holds 512 lines of 256 bits and moves one full cache line per request.
// Each request waits a fixed number of cycles, then raises a single-cycle acknowledge.
// The storage array "memory" is left visible so that bench code can preload it
// and flush lines into it.
module data_memory #(
  parameter int MEM_LATENCY = 10,
  parameter int DEPTH       = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   line_idx;
  logic               mem_we;
  logic               unused_addr_bits;

  // Reset never clears the line storage.
  logic [255:0] memory [0:DEPTH-1];

  // Only the line-index bits of the byte address matter. Higher addresses alias onto the same lines.
  assign line_idx         = addr_i[5 +: IDX_W];
  assign unused_addr_bits = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  // Next-state and latency counter.
  // The acknowledge is raised combinationally in the final wait cycle.
  // Dropping enable_i during the wait abandons the request.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ack_o   = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!enable_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == LAST_COUNT) begin
          ack_o   = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign mem_we = ack_o & write_i;

  // Read data is presented only during a read acknowledge.
  // At all other times data_o is zero.
  always_comb begin
    data_o = '0;
    if (ack_o && !write_i) begin
      data_o = memory[line_idx];
    end
  end

  // Control state registers, with an asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Line storage. A write commits at the edge that closes its acknowledge cycle.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      memory[line_idx] <= data_i;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed, self-checking bench for data_memory.
// Inputs are driven 1 time unit after each rising edge and outputs are sampled on the falling edge.
// Cycle 0 of a request is the cycle in which enable_i first goes high.
module tb_data_memory;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  int errors;
  int checks;

  localparam logic [255:0] LINE0  = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] LINE1  = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [255:0] LINE2  = {16{16'hECFA}};
  localparam logic [255:0] LINE16 = {2{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}};
  localparam logic [255:0] LINE17 = {8{32'h5A5A_A5A5}};
  localparam logic [255:0] LINE18 = {16{16'h1234}};
  localparam logic [255:0] LINE32 = 256'h0000_1001_2002_3003_4004_5005_6006_7007_8008_9009_A00A_B00B_C00C_D00D_E00E_F00F;
  localparam logic [255:0] WDATA  = {16{16'hABCD}};

  data_memory dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  // Free-running clock with a period of 10 time units.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // One comparison: count it, and report observed and expected values if they differ.
  task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Begin a request in the next cycle, which becomes cycle 0.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [255:0] data, input logic wr);
    @(posedge clk_i);
    #1;
    addr_i   = addr;
    data_i   = data;
    write_i  = wr;
    enable_i = 1'b1;
  endtask

  // Wait for the acknowledge, with a cycle budget.
  // Returns the cycle index relative to the current cycle and the data seen with the acknowledge.
  // Returns -1 if the budget runs out.
  task automatic wait_ack(output int cyc, output logic [255:0] rdata);
    cyc   = -1;
    rdata = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (ack_o === 1'b1) begin
        cyc   = c;
        rdata = data_o;
        break;
      end
    end
  endtask

  // Move to the next cycle and drop the request.
  task automatic end_request();
    @(posedge clk_i);
    #1;
    enable_i = 1'b0;
    write_i  = 1'b0;
  endtask

  initial begin
    int           cyc;
    int           ack_count;
    logic [255:0] rdata;

    errors   = 0;
    checks   = 0;
    rst_i    = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    enable_i = 1'b0;
    write_i  = 1'b0;

    dut.memory[0]  = LINE0;
    dut.memory[1]  = LINE1;
    dut.memory[2]  = LINE2;
    dut.memory[16] = LINE16;
    dut.memory[17] = LINE17;
    dut.memory[18] = LINE18;
    dut.memory[32] = LINE32;

    // Values held during reset.
    #2;
    check_output("reset_ack", 256'(ack_o), 256'd0);
    check_output("reset_data", data_o, '0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Read path: acknowledge exactly in cycle 10, then cleared in cycle 11.
    apply_stimulus(32'h0000_0000, '0, 1'b0);
    wait_ack(cyc, rdata);
    check_output("read_ack_cycle", 256'(cyc), 256'(10));
    check_output("read_data", rdata, LINE0);
    @(posedge clk_i);
    #1;
    enable_i = 1'b0;
    @(negedge clk_i);
    check_output("read_cycle11_ack", 256'(ack_o), 256'd0);
    check_output("read_cycle11_data", data_o, '0);

    // Write to line 18. The line changes only after the acknowledge edge.
    // Neighbouring line 17 must not change.
    apply_stimulus(32'h0000_0240, WDATA, 1'b1);
    wait_ack(cyc, rdata);
    check_output("write_ack_cycle", 256'(cyc), 256'(10));
    check_output("write_ack_data_zero", rdata, '0);
    check_output("write_mem18_before", dut.memory[18], LINE18);
    end_request();
    check_output("write_mem18_after", dut.memory[18], WDATA);
    check_output("write_mem17_kept", dut.memory[17], LINE17);

    // Back-to-back reads with enable held high.
    // The second acknowledge comes 11 cycles after the first (cycle 21).
    apply_stimulus(32'h0000_0020, '0, 1'b0);
    wait_ack(cyc, rdata);
    check_output("b2b_ack1_cycle", 256'(cyc), 256'(10));
    check_output("b2b_data1", rdata, LINE1);
    @(posedge clk_i);
    #1;
    addr_i = 32'h0000_0400;
    wait_ack(cyc, rdata);
    check_output("b2b_ack2_cycle", 256'(cyc + 11), 256'(21));
    check_output("b2b_data2", rdata, LINE32);
    end_request();

    // Abort: a write to line 2 is abandoned in cycle 5.
    // There must be no acknowledge and no write.
    apply_stimulus(32'h0000_0040, {16{16'h0BAD}}, 1'b1);
    ack_count = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (ack_o === 1'b1) ack_count++;
    end
    @(posedge clk_i);
    #1;
    enable_i = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_i);
      if (ack_o !== 1'b0) ack_count++;
    end
    check_output("abort_no_ack", 256'(ack_count), 256'd0);
    check_output("abort_mem2_kept", dut.memory[2], LINE2);
    apply_stimulus(32'h0000_0040, '0, 1'b0);
    wait_ack(cyc, rdata);
    check_output("abort_next_ack_cycle", 256'(cyc), 256'(10));
    check_output("abort_next_data", rdata, LINE2);
    end_request();

    // Reset asserted in cycle 7 of a write to line 16.
    // The acknowledge must drop at once and the line must not change.
    apply_stimulus(32'h0000_0200, {16{16'hDEAD}}, 1'b1);
    repeat (7) @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    enable_i = 1'b0;
    write_i  = 1'b0;
    #1;
    check_output("rst_mid_ack", 256'(ack_o), 256'd0);
    check_output("rst_mid_data", data_o, '0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    check_output("rst_mem16_kept", dut.memory[16], LINE16);
    apply_stimulus(32'h0000_0200, '0, 1'b0);
    wait_ack(cyc, rdata);
    check_output("rst_next_ack_cycle", 256'(cyc), 256'(10));
    check_output("rst_next_data", rdata, LINE16);
    end_request();

    // Alias: byte address 0x4020 maps to line 1.
    apply_stimulus(32'h0000_4020, '0, 1'b0);
    wait_ack(cyc, rdata);
    check_output("alias_ack_cycle", 256'(cyc), 256'(10));
    check_output("alias_data", rdata, LINE1);
    end_request();

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Off-chip main-memory model behind the data cache: 512 lines of 256 bits (16 KB), one full cache line per transfer. It sits outside the CPU on the cache–memory bus and answers each cache request with a fixed multi-cycle latency and a one-cycle acknowledge. The storage array is directly readable and writable by bench backdoor code, which preloads it and flushes dirty cache lines into it.

## Interface
- MEM_LATENCY, 10: cycles spent waiting between request acceptance and `ack_o`.
- DEPTH, 512: number of 256-bit lines. The index width is log2(DEPTH) = 9.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-low reset (0 = reset).
- addr_i  in  32  byte address. Line index = addr_i[13:5]; bits [4:0] and [31:14] are ignored.
- data_i  in  256  write line data.
- enable_i  in  1  request valid; must be held high until `ack_o`.
- write_i  in  1  1 = write, 0 = read; must be held stable with enable_i.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  256  read line data; valid only while `ack_o` is high.

## Operation
- Storage is an array named `memory`, indexed [0:DEPTH-1], 256 bits per entry.
  - Reset never clears it.
  - No initial contents are required, because the bench loads the array hierarchically.
- FSM states and transitions:
  - IDLE → WAIT when enable_i = 1 on a rising edge; count is set to 0.
  - WAIT with enable_i = 1 and count < MEM_LATENCY-1: count increments.
  - WAIT with enable_i = 1 and count = MEM_LATENCY-1: this is the ack cycle.
    - ack_o = 1 combinationally.
    - At the closing edge: if write_i = 1, memory[addr_i[13:5]] ← data_i.
    - Next state is IDLE.
  - WAIT with enable_i = 0 at any edge: abort. The next state is IDLE, with no write and no ack.
- Read data: data_o = memory[addr_i[13:5]] while ack_o = 1 and write_i = 0. Otherwise data_o = 0.
- addr_i, data_i and write_i are sampled at the ack cycle. The master keeps them stable for the whole transaction, and the block does not latch them.
- ack_o is never high outside WAIT.

## Timing
- Reset values while rst_i = 0 (asynchronous): state = IDLE, count = 0, ack_o = 0, data_o = 0.
- Latency: enable_i first high in cycle 0 (the IDLE cycle) gives ack_o high in cycle MEM_LATENCY (cycle 10 by default). The ack lasts exactly 1 cycle.
- A write is visible in `memory` starting with cycle MEM_LATENCY+1.
- Back-to-back requests: after an ack, the block spends one IDLE cycle before the next request is accepted.
  - If enable_i stays high after an ack, the next ack comes MEM_LATENCY+1 cycles after the previous one.
- Reset asserted mid-transaction: returns immediately to IDLE with ack_o = 0. No write occurs.
- Index wrap: addresses ≥ 0x4000 alias to addr_i[13:5]. For example, 0x4040 accesses line 2.

## Test plan
- Read hit path:
  - Stimulus: preload memory[0] = 0000_1111_…_EEEE_FFFF; enable_i = 1, write_i = 0, addr_i = 0x0000 in cycle 0.
  - Required: ack_o = 0 in cycles 0–9; in cycle 10, ack_o = 1 and data_o equals the preloaded line; in cycle 11, ack_o = 0 and data_o = 0.
- Write:
  - Stimulus: addr_i = 0x0240, data_i = {16{16'hABCD}}, write_i = 1, enable_i held high.
  - Required: ack_o in cycle 10; memory[18] = {16{16'hABCD}} from cycle 11; memory[17] is unchanged.
- Back-to-back:
  - Stimulus: read 0x0020, then immediately read 0x0400 with enable_i held high.
  - Required: acks in cycles 10 and 21. The data returned is memory[1] = 8888_9999_…_0000, then memory[32] = 0000_1001_…_F00F.
- Abort:
  - Stimulus: write request to 0x0040; drop enable_i in cycle 5.
  - Required: no ack occurs; memory[2] keeps ECFA…ECFA; a new request starts a fresh 10-cycle count.
- Reset mid-operation:
  - Stimulus: rst_i = 0 in cycle 7 of a write to 0x0200, held for 1 cycle.
  - Required: ack_o = 0 immediately; memory[16] is unchanged (0123_4567_…_3210); the next request completes after a full 10 cycles.
- Alias:
  - Stimulus: read 0x4020.
  - Required: returns memory[1].
